// File: rtl/command_path_arbiter.sv
// Shares one 64-bit Command bus between NUM_REQ sources, each buffered in a show-ahead FIFO.
// Commands move whole (head..tail) under round-robin; one cycle from pop to Command.
module command_path_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int FIFO_DEPTH  = 16,
  parameter int ALF_LEVEL   = 12,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [NUM_REQ-1:0]     Req_command_wr,
  input  logic [64*NUM_REQ-1:0]  Req_command,
  output logic [NUM_REQ-1:0]     Req_command_alf,
  output logic                   Command_wr,
  output logic [63:0]            Command,
  input  logic                   Command_alf,
  output logic [31:0]            com_out_cnt,
  output logic [31:0]            err_cnt,
  output logic [31:0]            drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ALF_CNT  = CW'(ALF_LEVEL);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT_CYC);
  localparam logic [63:0]   ABORT_TAIL = {3'b110, 1'b0, 60'b0};

  localparam logic [0:0] ARB_S  = 1'b0;
  localparam logic [0:0] LOCK_S = 1'b1;

  localparam logic [2:0] T_HEAD = 3'b101;
  localparam logic [2:0] T_BODY = 3'b111;
  localparam logic [2:0] T_TAIL = 3'b110;
  localparam logic [2:0] T_ONE  = 3'b100;

  logic [NUM_REQ-1:0][63:0] head;
  logic [NUM_REQ-1:0]       empty;
  logic [NUM_REQ-1:0]       pop;
  logic [NUM_REQ-1:0]       drop;

  // Per-requester show-ahead buffers; head[i] is valid whenever empty[i] is low.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          alf_q, alf_d;
    logic          push;

    always_comb begin
      push     = Req_command_wr[i] && ((cnt_q != FULL_CNT) || pop[i]);
      wr_ptr_d = push   ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop[i] ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({push, pop[i]})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
      alf_d = (cnt_d >= ALF_CNT);
    end

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        alf_q    <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        alf_q    <= alf_d;
      end
    end

    always_ff @(posedge Clk) begin
      if (push) mem[wr_ptr_q] <= Req_command[64*i +: 64];
    end

    assign head[i]            = mem[rd_ptr_q];
    assign empty[i]           = (cnt_q == '0);
    assign drop[i]            = Req_command_wr[i] && !push;
    assign Req_command_alf[i] = alf_q;
  end

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] rr_q, rr_d;
  logic [PW-1:0] grant_q, grant_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          cmd_wr_q, cmd_wr_d;
  logic [63:0]   cmd_q, cmd_d;
  logic [31:0]   com_cnt_q, com_cnt_d;
  logic [31:0]   err_cnt_q, err_cnt_d;
  logic [31:0]   drop_cnt_q, drop_cnt_d;

  logic          found;
  logic [PW-1:0] sel;
  logic [2:0]    sel_typ;
  logic [2:0]    lock_typ;
  logic          err_inc;
  logic [2:0]    drop_n;

  // Round-robin search starting just after the last requester that finished a command.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && !empty[(int'(rr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        sel   = PW'((int'(rr_q) + k) % NUM_REQ);
      end
    end
    sel_typ  = head[sel][63:61];
    lock_typ = head[grant_q][63:61];
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    grant_d  = grant_q;
    timer_d  = timer_q;
    pop      = '0;
    cmd_wr_d = 1'b0;
    cmd_d    = '0;
    err_inc  = 1'b0;
    case (state_q)
      ARB_S: begin
        if (!Command_alf && found) begin
          pop[sel] = 1'b1;
          case (sel_typ)
            T_ONE: begin
              cmd_wr_d = 1'b1;
              cmd_d    = head[sel];
              rr_d     = sel;
            end
            T_HEAD: begin
              cmd_wr_d = 1'b1;
              cmd_d    = head[sel];
              grant_d  = sel;
              timer_d  = '0;
              state_d  = LOCK_S;
            end
            default: err_inc = 1'b1;
          endcase
        end
      end
      default: begin
        if (empty[grant_q]) begin
          // The timer keeps running while stalled so the abort fires as soon as alf drops.
          if (timer_q != TMAX) begin
            timer_d = timer_q + TW'(1);
          end else if (!Command_alf) begin
            cmd_wr_d = 1'b1;
            cmd_d    = ABORT_TAIL;
            err_inc  = 1'b1;
            rr_d     = grant_q;
            state_d  = ARB_S;
          end
        end else if (!Command_alf) begin
          case (lock_typ)
            T_BODY: begin
              pop[grant_q] = 1'b1;
              cmd_wr_d     = 1'b1;
              cmd_d        = head[grant_q];
              timer_d      = '0;
            end
            T_TAIL: begin
              pop[grant_q] = 1'b1;
              cmd_wr_d     = 1'b1;
              cmd_d        = head[grant_q];
              rr_d         = grant_q;
              state_d      = ARB_S;
            end
            T_HEAD, T_ONE: begin
              // Leave the new head queued; it is re-arbitrated after the abort tail.
              cmd_wr_d = 1'b1;
              cmd_d    = ABORT_TAIL;
              err_inc  = 1'b1;
              rr_d     = grant_q;
              state_d  = ARB_S;
            end
            default: begin
              pop[grant_q] = 1'b1;
              err_inc      = 1'b1;
            end
          endcase
        end
      end
    endcase
  end

  always_comb begin
    drop_n = '0;
    for (int i = 0; i < NUM_REQ; i++) drop_n = drop_n + {2'b00, drop[i]};
    com_cnt_d  = com_cnt_q + {31'b0, cmd_wr_d};
    err_cnt_d  = err_cnt_q + {31'b0, err_inc};
    drop_cnt_d = drop_cnt_q + {29'b0, drop_n};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ARB_S;
      rr_q       <= PW'(NUM_REQ - 1);
      grant_q    <= '0;
      timer_q    <= '0;
      cmd_wr_q   <= 1'b0;
      cmd_q      <= '0;
      com_cnt_q  <= '0;
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      timer_q    <= timer_d;
      cmd_wr_q   <= cmd_wr_d;
      cmd_q      <= cmd_d;
      com_cnt_q  <= com_cnt_d;
      err_cnt_q  <= err_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign Command_wr  = cmd_wr_q;
  assign Command     = cmd_q;
  assign com_out_cnt = com_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign drop_cnt    = drop_cnt_q;

endmodule
